// File: rtl/udp_rx_noc_out_mcast.sv
// rtl/udp_rx_noc_out_mcast.sv - UDP receive path buffering a payload and multicasting it as NoC packets
module udp_rx_noc_out_mcast #(
    parameter int SRC_X = -1,
    parameter int SRC_Y = -1,
    parameter int DATA_W = 256,
    parameter int MAX_COPIES = 4,
    parameter int BUF_DEPTH = 64,
    parameter int X_W = 4,
    parameter int Y_W = 4,
    parameter int TS_W = 64,
    parameter logic [7:0] MSG_TYPE = 8'h01,
    localparam int PAD_W = $clog2(DATA_W / 8),
    localparam int CNT_W = $clog2(MAX_COPIES + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        hdr_val,
    output logic                        hdr_rdy,
    input  logic [31:0]                 hdr_src_ip,
    input  logic [31:0]                 hdr_dst_ip,
    input  logic [15:0]                 hdr_src_port,
    input  logic [15:0]                 hdr_dst_port,
    input  logic [15:0]                 hdr_udp_len,
    input  logic [TS_W-1:0]             hdr_timestamp,
    input  logic                        data_val,
    input  logic                        data_last,
    input  logic [DATA_W-1:0]           data,
    input  logic [PAD_W-1:0]            data_padbytes,
    output logic                        data_rdy,
    output logic                        cam_rd_val,
    output logic [15:0]                 cam_rd_tag,
    input  logic                        cam_rd_hit,
    input  logic [CNT_W-1:0]            cam_rd_cnt,
    input  logic [MAX_COPIES*X_W-1:0]   cam_rd_dst_x,
    input  logic [MAX_COPIES*Y_W-1:0]   cam_rd_dst_y,
    output logic                        noc_val,
    output logic [DATA_W-1:0]           noc_data,
    input  logic                        noc_rdy,
    output logic [31:0]                 pkt_cnt,
    output logic [31:0]                 drop_cnt
);

    localparam int BYTES     = DATA_W / 8;
    localparam int AW        = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int NW        = $clog2(BUF_DEPTH + 1);
    localparam int HDR_BITS  = 2 * X_W + 2 * Y_W + 24;
    localparam int META_BITS = 32 * 2 + 16 * 3 + TS_W;
    localparam logic [X_W-1:0] SRC_X_L = X_W'(SRC_X);
    localparam logic [Y_W-1:0] SRC_Y_L = Y_W'(SRC_Y);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_BUFFER = 3'd2;
    localparam logic [2:0] S_DROP   = 3'd3;
    localparam logic [2:0] S_HDR    = 3'd4;
    localparam logic [2:0] S_META   = 3'd5;
    localparam logic [2:0] S_DATA   = 3'd6;

    logic [2:0]                 state;
    logic [31:0]                src_ip_r, dst_ip_r;
    logic [15:0]                src_port_r, dst_port_r, udp_len_r;
    logic [TS_W-1:0]            ts_r;
    logic [CNT_W-1:0]           cnt_r, copy_r;
    logic [MAX_COPIES*X_W-1:0]  dst_x_r;
    logic [MAX_COPIES*Y_W-1:0]  dst_y_r;
    logic [NW-1:0]              n_r, rd_r;
    logic [DATA_W-1:0]          buf_mem [BUF_DEPTH];

    logic [16:0]                pay_bytes, w_calc;
    logic                       accept, copy_done, more_copies;
    logic [DATA_W-1:0]          hdr_flit, meta_flit;

    // Payload word count and CAM acceptance decision for the captured header
    always_comb begin
        pay_bytes   = (udp_len_r < 16'd8) ? 17'd0 : ({1'b0, udp_len_r} - 17'd8);
        w_calc      = (pay_bytes + 17'(BYTES - 1)) >> PAD_W;
        accept      = cam_rd_hit && (cam_rd_cnt != '0) && (cam_rd_cnt <= CNT_W'(MAX_COPIES))
                      && (w_calc <= 17'(BUF_DEPTH));
        more_copies = ((CNT_W + 1)'(copy_r) + 1'b1) < (CNT_W + 1)'(cnt_r);
        copy_done   = !rst && noc_rdy &&
                      (((state == S_META) && (n_r == '0)) ||
                       ((state == S_DATA) && ((rd_r + 1'b1) == n_r)));
    end

    // Header and meta flit assembly, MSB-first with zero fill below
    always_comb begin
        hdr_flit  = '0;
        meta_flit = '0;
        hdr_flit[DATA_W-1 -: HDR_BITS] = {dst_x_r[copy_r*X_W +: X_W], dst_y_r[copy_r*Y_W +: Y_W],
                                          SRC_X_L, SRC_Y_L, 16'(n_r) + 16'd1, MSG_TYPE};
        meta_flit[DATA_W-1 -: META_BITS] = {src_ip_r, dst_ip_r, src_port_r, dst_port_r,
                                            udp_len_r, ts_r};
    end

    // Handshake outputs; all forced low while reset is held
    always_comb begin
        hdr_rdy    = !rst && (state == S_IDLE);
        data_rdy   = !rst && ((state == S_BUFFER) || (state == S_DROP));
        cam_rd_val = !rst && (state == S_LOOKUP);
        cam_rd_tag = dst_port_r;
        noc_val    = !rst && ((state == S_HDR) || (state == S_META) || (state == S_DATA));
        case (state)
            S_HDR:   noc_data = hdr_flit;
            S_META:  noc_data = meta_flit;
            S_DATA:  noc_data = buf_mem[rd_r[AW-1:0]];
            default: noc_data = '0;
        endcase
    end

    // Payload buffer write port; pad-byte count is carried by udp_len, not stored
    always_ff @(posedge clk) begin
        if (data_rdy && data_val && (state == S_BUFFER)) begin
            buf_mem[n_r[AW-1:0]] <= data;
        end
    end

    // Packet FSM: capture, lookup, buffer or drop, then replay header/meta/data per copy
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            copy_r   <= '0;
            n_r      <= '0;
            rd_r     <= '0;
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: if (hdr_val) begin
                    src_ip_r   <= hdr_src_ip;
                    dst_ip_r   <= hdr_dst_ip;
                    src_port_r <= hdr_src_port;
                    dst_port_r <= hdr_dst_port;
                    udp_len_r  <= hdr_udp_len;
                    ts_r       <= hdr_timestamp;
                    state      <= S_LOOKUP;
                end
                S_LOOKUP: begin
                    n_r    <= '0;
                    rd_r   <= '0;
                    copy_r <= '0;
                    if (accept) begin
                        cnt_r   <= cam_rd_cnt;
                        dst_x_r <= cam_rd_dst_x;
                        dst_y_r <= cam_rd_dst_y;
                        state   <= (w_calc != '0) ? S_BUFFER : S_HDR;
                    end else begin
                        if (drop_cnt != 32'hFFFF_FFFF) drop_cnt <= drop_cnt + 32'd1;
                        state <= (w_calc != '0) ? S_DROP : S_IDLE;
                    end
                end
                S_BUFFER: if (data_val) begin
                    n_r <= n_r + 1'b1;
                    if (data_last || ((17'(n_r) + 17'd1) == w_calc)) state <= S_HDR;
                end
                S_DROP: if (data_val && data_last) state <= S_IDLE;
                S_HDR: if (noc_rdy) state <= S_META;
                S_META: if (noc_rdy) begin
                    rd_r  <= '0;
                    state <= S_DATA;
                end
                S_DATA: if (noc_rdy) rd_r <= rd_r + 1'b1;
                default: state <= S_IDLE;
            endcase
            if (copy_done) begin
                rd_r <= '0;
                if (more_copies) begin
                    copy_r <= copy_r + 1'b1;
                    state  <= S_HDR;
                end else begin
                    if (pkt_cnt != 32'hFFFF_FFFF) pkt_cnt <= pkt_cnt + 32'd1;
                    state <= S_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_udp_rx_noc_out_mcast.sv
// tb/tb_udp_rx_noc_out_mcast.sv - directed vector bench for udp_rx_noc_out_mcast
module tb_udp_rx_noc_out_mcast;

    logic         clk = 1'b0;
    logic         rst;
    logic         hdr_val, hdr_rdy;
    logic [31:0]  hdr_src_ip, hdr_dst_ip;
    logic [15:0]  hdr_src_port, hdr_dst_port, hdr_udp_len;
    logic [63:0]  hdr_timestamp;
    logic         data_val, data_last, data_rdy;
    logic [255:0] data;
    logic [4:0]   data_padbytes;
    logic         cam_rd_val, cam_rd_hit;
    logic [15:0]  cam_rd_tag;
    logic [2:0]   cam_rd_cnt;
    logic [15:0]  cam_rd_dst_x, cam_rd_dst_y;
    logic         noc_val, noc_rdy;
    logic [255:0] noc_data;
    logic [31:0]  pkt_cnt, drop_cnt;

    udp_rx_noc_out_mcast #(.SRC_X(2), .SRC_Y(7)) dut (
        .clk(clk), .rst(rst), .hdr_val(hdr_val), .hdr_rdy(hdr_rdy),
        .hdr_src_ip(hdr_src_ip), .hdr_dst_ip(hdr_dst_ip), .hdr_src_port(hdr_src_port),
        .hdr_dst_port(hdr_dst_port), .hdr_udp_len(hdr_udp_len), .hdr_timestamp(hdr_timestamp),
        .data_val(data_val), .data_last(data_last), .data(data), .data_padbytes(data_padbytes),
        .data_rdy(data_rdy), .cam_rd_val(cam_rd_val), .cam_rd_tag(cam_rd_tag),
        .cam_rd_hit(cam_rd_hit), .cam_rd_cnt(cam_rd_cnt), .cam_rd_dst_x(cam_rd_dst_x),
        .cam_rd_dst_y(cam_rd_dst_y), .noc_val(noc_val), .noc_data(noc_data), .noc_rdy(noc_rdy),
        .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int udp_len;
        bit hit;
        int cnt;
        int beats;
        bit last_on_final;
        bit rnd_rdy;
        bit exp_acc;
        int exp_n;
    } vec_t;

    vec_t         vecs [12];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           exp_pkt = 0;
    int           exp_drop = 0;
    bit           rnd_mode = 0;
    logic [255:0] flits [$];
    logic [255:0] expq [$];
    logic [255:0] payload [70];
    int           consumed, rdy_cycles, lookups;
    logic [15:0]  last_tag;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Flit, beat and lookup observer
    always @(posedge clk) begin
        if (!rst) begin
            if (noc_val && noc_rdy) flits.push_back(noc_data);
            if (data_val && data_rdy) consumed++;
            if (data_rdy) rdy_cycles++;
            if (cam_rd_val) begin
                lookups++;
                last_tag = cam_rd_tag;
            end
        end
    end

    // NoC backpressure generator
    always @(negedge clk) noc_rdy = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;

    task automatic send_hdr(input int ulen, input bit hit, input int cnt, input int idx);
        bit ok = 0;
        cam_rd_hit    = hit;
        cam_rd_cnt    = 3'(cnt);
        hdr_src_ip    = $urandom;
        hdr_dst_ip    = $urandom;
        hdr_src_port  = 16'($urandom);
        hdr_dst_port  = 16'h1000 + 16'(idx);
        hdr_udp_len   = 16'(ulen);
        hdr_timestamp = {$urandom, $urandom};
        for (int i = 0; i < 70; i++) payload[i] = {8{$urandom}};
        flits.delete();
        consumed = 0; rdy_cycles = 0; lookups = 0;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (hdr_rdy) begin ok = 1; break; end
        end
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL hdr_rdy_timeout actual=0 required=1");
        end
        hdr_val = 1'b1;
        @(posedge clk); #1;
        hdr_val = 1'b0;
    endtask

    task automatic send_beats(input int beats, input bit last_on_final);
        for (int b = 0; b < beats; b++) begin
            bit ok = 0;
            data      = payload[b];
            data_last = last_on_final && (b == beats - 1);
            data_val  = 1'b1;
            for (int t = 0; t < 2000; t++) begin
                @(negedge clk);
                if (data_rdy) begin ok = 1; break; end
            end
            if (!ok) begin
                n_tests++; n_fail++;
                $display("FAIL data_rdy_timeout beat=%0d actual=0 required=1", b);
            end
            @(posedge clk); #1;
        end
        data_val  = 1'b0;
        data_last = 1'b0;
    endtask

    task automatic finish_and_check(input string tag, input vec_t v);
        bit ok = 0;
        logic [255:0] f;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (hdr_rdy) begin ok = 1; break; end
        end
        check({tag, "_idle"}, 256'(ok), 256'd1);
        expq.delete();
        if (v.exp_acc) begin
            for (int c = 0; c < v.cnt; c++) begin
                f = '0;
                f[255 -: 40] = {4'(10 - c), 4'(3 + c), 4'd2, 4'd7, 16'(v.exp_n + 1), 8'h01};
                expq.push_back(f);
                f = '0;
                f[255 -: 176] = {hdr_src_ip, hdr_dst_ip, hdr_src_port, hdr_dst_port, hdr_udp_len, hdr_timestamp};
                expq.push_back(f);
                for (int i = 0; i < v.exp_n; i++) expq.push_back(payload[i]);
            end
            exp_pkt++;
        end else begin
            exp_drop++;
        end
        check({tag, "_nflits"}, 256'(flits.size()), 256'(expq.size()));
        for (int i = 0; i < expq.size() && i < flits.size(); i++)
            check($sformatf("%s_flit%0d", tag, i), flits[i], expq[i]);
        check({tag, "_consumed"}, 256'(consumed), 256'(v.beats));
        check({tag, "_rdy_cycles"}, 256'(rdy_cycles), 256'(v.beats));
        check({tag, "_lookups"}, 256'(lookups), 256'd1);
        check({tag, "_cam_tag"}, 256'(last_tag), 256'(hdr_dst_port));
        check({tag, "_pkt_cnt"}, 256'(pkt_cnt), 256'(exp_pkt));
        check({tag, "_drop_cnt"}, 256'(drop_cnt), 256'(exp_drop));
    endtask

    initial begin
        //          ulen hit cnt beats last rnd acc  n
        vecs[0]  = '{72,   1, 3,  2,  1, 0, 1,  2};
        vecs[1]  = '{40,   0, 1,  1,  1, 0, 0,  0};
        vecs[2]  = '{8,    1, 2,  0,  1, 0, 1,  0};
        vecs[3]  = '{2088, 1, 1, 65,  1, 0, 0,  0};
        vecs[4]  = '{72,   1, 3,  2,  1, 1, 1,  2};
        vecs[5]  = '{136,  1, 2,  2,  1, 0, 1,  2};
        vecs[6]  = '{104,  1, 1,  3,  0, 0, 1,  3};
        vecs[7]  = '{40,   1, 0,  1,  1, 0, 0,  0};
        vecs[8]  = '{8,    1, 5,  0,  1, 0, 0,  0};
        vecs[9]  = '{75,   1, 4,  3,  1, 1, 1,  3};
        vecs[10] = '{4,    1, 1,  0,  1, 0, 1,  0};
        vecs[11] = '{2056, 1, 1, 64,  1, 0, 1, 64};

        for (int i = 0; i < 4; i++) begin
            cam_rd_dst_x[i*4 +: 4] = 4'(10 - i);
            cam_rd_dst_y[i*4 +: 4] = 4'(3 + i);
        end
        hdr_val = 0; data_val = 0; data_last = 0; data = '0; data_padbytes = '0;
        cam_rd_hit = 0; cam_rd_cnt = 0;
        hdr_src_ip = 0; hdr_dst_ip = 0; hdr_src_port = 0; hdr_dst_port = 0;
        hdr_udp_len = 0; hdr_timestamp = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hdr_rdy", 256'(hdr_rdy), 256'd0);
        check("rst_data_rdy", 256'(data_rdy), 256'd0);
        check("rst_noc_val", 256'(noc_val), 256'd0);
        check("rst_cam_rd_val", 256'(cam_rd_val), 256'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_hdr_rdy", 256'(hdr_rdy), 256'd1);
        check("post_rst_pkt_cnt", 256'(pkt_cnt), 256'd0);
        check("post_rst_drop_cnt", 256'(drop_cnt), 256'd0);

        for (int v = 0; v < 12; v++) begin
            rnd_mode = vecs[v].rnd_rdy;
            send_hdr(vecs[v].udp_len, vecs[v].hit, vecs[v].cnt, v);
            send_beats(vecs[v].beats, vecs[v].last_on_final);
            finish_and_check($sformatf("v%0d", v), vecs[v]);
        end
        rnd_mode = 0;

        // Reset while copy 1 is in its DATA phase
        send_hdr(72, 1, 3, 20);
        send_beats(2, 1);
        begin
            bit ok = 0;
            for (int t = 0; t < 2000; t++) begin
                @(negedge clk);
                if (flits.size() >= 6) begin ok = 1; break; end
            end
            check("rst_mid_reach", 256'(ok), 256'd1);
        end
        rst = 1'b1;
        #1;
        check("rst_mid_noc_val", 256'(noc_val), 256'd0);
        @(posedge clk); #1;
        check("rst_mid_noc_val2", 256'(noc_val), 256'd0);
        check("rst_mid_pkt_cnt", 256'(pkt_cnt), 256'd0);
        check("rst_mid_drop_cnt", 256'(drop_cnt), 256'd0);
        check("rst_mid_hdr_rdy", 256'(hdr_rdy), 256'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_release_hdr_rdy", 256'(hdr_rdy), 256'd1);
        repeat (5) @(posedge clk);
        #1;
        check("rst_mid_no_more_flits", 256'(flits.size()), 256'd6);
        exp_pkt = 0;
        exp_drop = 0;
        send_hdr(vecs[0].udp_len, vecs[0].hit, vecs[0].cnt, 21);
        send_beats(vecs[0].beats, vecs[0].last_on_final);
        finish_and_check("after_rst", vecs[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/udp_rx_noc_out_mcast.md
UDP_RX_NOC_OUT_MCAST -- requirements
Module: udp_rx_noc_out_mcast

Interface
REQ-001 SHALL have parameter SRC_X, default -1: X coordinate of this tile, placed in every header flit.
REQ-002 SHALL have parameter SRC_Y, default -1: Y coordinate of this tile.
REQ-003 SHALL have parameter DATA_W, default 256: width of a MAC word and of a NoC flit.
REQ-004 SHALL have parameter MAX_COPIES, default 4: maximum number of destinations per packet.
REQ-005 SHALL have parameter BUF_DEPTH, default 64: payload buffer size in DATA_W words.
REQ-006 SHALL have parameters X_W=4, Y_W=4, TS_W=64, and MSG_TYPE=8'h01; PAD_W SHALL equal clog2(DATA_W/8).
REQ-007 clk  in  1  sole clock; all logic on rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 hdr_val/hdr_rdy  in/out  1/1  header handshake.
REQ-010 hdr_src_ip, hdr_dst_ip  in  32 each  IP addresses.
REQ-011 hdr_src_port, hdr_dst_port, hdr_udp_len  in  16 each  UDP header fields; udp_len counts header plus payload bytes.
REQ-012 hdr_timestamp  in  TS_W  arrival timestamp.
REQ-013 data_val, data_last  in  1 each; data  in  DATA_W; data_padbytes  in  PAD_W; data_rdy  out  1.
REQ-014 cam_rd_val  out  1; cam_rd_tag  out  16 (dst_port); cam_rd_hit  in  1; cam_rd_cnt  in  clog2(MAX_COPIES+1); cam_rd_dst_x  in  MAX_COPIES*X_W; cam_rd_dst_y  in  MAX_COPIES*Y_W (copy i occupies slice i). The response is combinational in the same cycle.
REQ-015 noc_val  out  1; noc_data  out  DATA_W; noc_rdy  in  1.
REQ-016 pkt_cnt, drop_cnt  out  32 each  saturating statistics counters.

Function
REQ-017 The FSM SHALL have states IDLE, LOOKUP, BUFFER, DROP, HDR, META, DATA.
REQ-018 IDLE: hdr_rdy=1 only in this state; on hdr_val, all header fields SHALL be captured and the FSM SHALL go to LOOKUP.
REQ-019 Payload word count SHALL be computed as W = ceil((udp_len-8)/(DATA_W/8)); udp_len<8 SHALL be treated as W=0.
REQ-020 LOOKUP (1 cycle): cam_rd_val=1 and cam_rd_tag=captured dst_port.
- Packet accepted when hit=1, 1<=cnt<=MAX_COPIES, and W<=BUF_DEPTH.
- Accepted: latch cnt and dst arrays; go to BUFFER if W>0, else HDR.
- Rejected: drop_cnt+1; go to DROP if W>0, else IDLE.
REQ-021 BUFFER: data_rdy=1; each accepted beat SHALL be written at the next buffer index starting at 0. On the beat with data_last, go to HDR with copy index 0.
REQ-022 A beat with data_last arriving before W beats, or beat W arriving without data_last, SHALL end buffering at that beat. The FSM SHALL then go to HDR; DATA emits only the beats actually written.
REQ-023 DROP: data_rdy=1; beats are discarded until the data_last beat, then the FSM SHALL go to IDLE.
REQ-024 Header flit, MSB-first:
- dst_x[copy], dst_y[copy], SRC_X, SRC_Y
- num_flits (16b) = 1 + written words
- MSG_TYPE (8b)
- remaining bits zero
REQ-025 Meta flit, MSB-first: src_ip, dst_ip, src_port, dst_port, udp_len, timestamp; remaining bits zero.
REQ-026 HDR→META→DATA: each flit SHALL hold noc_val=1 and stable noc_data until noc_rdy; advance SHALL occur on val&rdy only.
REQ-027 DATA SHALL emit buffer words 0..n-1 unchanged; with n=0, META SHALL exit directly to the copy-completion step.
REQ-028 Copy completion:
- If copy+1<cnt: copy+1, go to HDR; the buffer SHALL be re-read from index 0.
- Else: pkt_cnt+1, go to IDLE.
REQ-029 noc_val SHALL be 0 outside HDR/META/DATA; data_rdy SHALL be 0 outside BUFFER/DROP.
REQ-030 Counters SHALL saturate at 32'hFFFFFFFF.
REQ-031 A new header SHALL NOT be accepted until all copies of the current packet have been sent; there is no overlap between packets.

Reset
REQ-032 On rst, the FSM SHALL go to IDLE, copy index and buffer pointers SHALL clear, and pkt_cnt=drop_cnt=0.
REQ-033 During rst: hdr_rdy=0, data_rdy=0, noc_val=0, cam_rd_val=0; hdr_rdy=1 SHALL assert the first cycle after rst deasserts.
REQ-034 rst mid-packet SHALL discard all partial state; no further flits of that packet SHALL be emitted.

Verification
REQ-035 DATA_W=256, udp_len=72 (W=2), hit with cnt=3 → 12 flits (3×[HDR, META, D0, D1]) with dst slices 0,1,2, num_flits=3 each, pkt_cnt=1.
REQ-036 Miss with udp_len=40 → 1 beat consumed, no flits, drop_cnt=1, hdr_rdy back to 1.
REQ-037 udp_len=8, hit with cnt=2 → no data beats consumed; flits HDR, META, HDR, META with num_flits=1.
REQ-038 udp_len = 8+32×(BUF_DEPTH+1) → drop, all BUF_DEPTH+1 beats consumed, drop_cnt=1.
REQ-039 noc_rdy randomly deasserted 50% of cycles → flit sequence and contents identical to the noc_rdy=1 run.
REQ-040 rst asserted during DATA of copy 1 → noc_val=0 next cycle, counters=0, and the next packet is sent intact.
